next_pc_control: RTL
====================

Name: next_pc_control

Overview:
- Generates the next fetch address and the stop request for the program counter. Its outputs are `pc_new_address` and `pc_stop`.
- Consumes the current `instruction_address` returned by the PC, plus redirect, hazard and halt requests from the decode/execute stages.
- Owns the front-end control FSM: normal sequencing, multi-cycle stalls, branch/jump redirects with pipeline flush, and a sticky halt.
- Instructions are 16-bit and byte-addressed, so sequential advance is +2.

Parameters:
- STALL_CYCLES, 1: total cycles `pc_stop` is held for one `hazard_stall` request (range 1..15).
- FLUSH_CYCLES, 2: cycles `flush` is held after a redirect (range 1..15).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- instruction_address  in  16  current PC value from the program counter.
- branch_taken  in  1  conditional branch resolved taken this cycle.
- branch_base  in  16  address of the branch instruction plus 2.
- branch_offset  in  8  signed word offset.
- jump  in  1  unconditional jump this cycle.
- jump_target  in  16  absolute jump address.
- hazard_stall  in  1  load-use hazard detected.
- halt  in  1  halt instruction retired.
- pc_new_address  out  16  address the PC loads next edge.
- pc_stop  out  1  PC must hold its value.
- flush  out  1  kill IF/ID contents.
- npc_state  out  2  FSM state: 0=RUN, 1=STALL, 2=FLUSH, 3=HALT.

Behaviour:
- Registered state: FSM state (2 bits) and a 4-bit down-counter `cnt`. Outputs are combinational from state, `cnt` and inputs (zero latency).
- Async reset: state=RUN, cnt=0.
  - While reset is asserted, or with idle inputs after reset: pc_stop=0, flush=0, npc_state=0, pc_new_address=instruction_address+2.
- Default sequencing: pc_new_address = instruction_address + 2, modulo 2^16 (0xFFFE -> 0x0000).
- Redirect target:
  - redirect = branch_taken | jump.
  - If jump: target = {jump_target[15:1],1'b0}.
  - Else: target = branch_base + (sign_extend(branch_offset) << 1), modulo 2^16.
  - jump wins over branch_taken if both are high.
- Priority each cycle: halt > redirect > hazard_stall.
- RUN:
  - halt: pc_stop=1, next=HALT.
  - redirect: pc_new_address=target, pc_stop=0, flush=1. If FLUSH_CYCLES>1, next=FLUSH with cnt=FLUSH_CYCLES-2; else stay RUN.
  - hazard_stall: pc_stop=1, pc_new_address=instruction_address. If STALL_CYCLES>1, next=STALL with cnt=STALL_CYCLES-2; else stay RUN.
- STALL:
  - pc_stop=1, pc_new_address=instruction_address.
  - cnt==0 -> RUN; else cnt-1.
  - A new hazard_stall here is ignored (no extension).
  - Redirect aborts the stall and behaves exactly as a redirect in RUN.
  - halt -> HALT.
- FLUSH:
  - flush=1, pc_stop=0, sequential advance.
  - cnt==0 -> RUN; else cnt-1.
  - A new redirect restarts the flush (new target, cnt reloaded).
  - hazard_stall is ignored (the flushed instruction is dead).
  - halt -> HALT.
- HALT:
  - pc_stop=1, flush=0, pc_new_address=instruction_address.
  - Sticky; only reset exits.
  - All other inputs are ignored.
- Reset mid-stall or mid-flush: returns to RUN immediately; pc_stop and flush drop in the same cycle.
- No X propagation: unknown inputs during reset must not reach state.

Optional Feature:
- Macro: NPC_REDIRECT_COUNT_EN.
- Defined:
  - Adds output `redirect_count` (16 bits), reset to 0.
  - Increments on every cycle where a redirect is accepted (RUN, STALL or FLUSH, and not halting).
  - Saturates at 0xFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, instruction_address=0x1111 -> pc_new_address=0x1113, pc_stop=0, flush=0, npc_state=0. With instruction_address=0xFFFE -> pc_new_address=0x0000.
- branch_taken=1, branch_base=0x0102, branch_offset=0xFC -> pc_new_address=0x00FA, flush=1 for 2 cycles, then RUN. Same with jump=1, jump_target=0xABCD asserted together -> 0xABCC, jump wins.
- STALL_CYCLES=3, hazard_stall pulsed 1 cycle at instruction_address=0x0040 -> pc_stop=1 for exactly 3 cycles, pc_new_address=0x0040 throughout, then 0x0042.
- STALL_CYCLES=3, branch_taken on 2nd stall cycle -> pc_stop drops that cycle, target driven, flush=1, state FLUSH.
- halt with simultaneous jump -> HALT, pc_stop=1 indefinitely, jump ignored. Assert reset asynchronously mid-cycle -> npc_state=0, pc_stop=0 before the next edge.
- NPC_REDIRECT_COUNT_EN defined: 3 redirects (one during FLUSH), then halt with a redirect -> redirect_count=3.

Source files
------------

// File: rtl/next_pc_control.sv
// next_pc_control: front-end FSM producing next PC, stop and flush; NPC_REDIRECT_COUNT_EN adds a saturating redirect counter.
module next_pc_control #(
  parameter int STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instruction_address,
  input  logic        branch_taken,
  input  logic [15:0] branch_base,
  input  logic [7:0]  branch_offset,
  input  logic        jump,
  input  logic [15:0] jump_target,
  input  logic        hazard_stall,
  input  logic        halt,
  output logic [15:0] pc_new_address,
  output logic        pc_stop,
  output logic        flush,
  output logic [1:0]  npc_state
`ifdef NPC_REDIRECT_COUNT_EN
  ,
  output logic [15:0] redirect_count
`endif
);
  localparam logic [1:0] RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2, HALT = 2'd3;
  logic [1:0]  state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [15:0] target;
  logic        active, take_halt, take_redir, take_stall;
  // Requests are masked while reset is held so nothing but RUN is ever visible then.
  assign active     = !reset && state != HALT;
  assign take_halt  = active && halt;
  assign take_redir = active && !halt && (branch_taken || jump);
  assign take_stall = active && state == RUN && !halt && !(branch_taken || jump) && hazard_stall;
  assign target     = jump ? {jump_target[15:1], 1'b0}
                           : branch_base + {{7{branch_offset[7]}}, branch_offset, 1'b0};
  assign pc_stop    = state == HALT || take_halt || take_stall || (state == STALL && !take_redir);
  assign flush      = take_redir || (state == FLUSH && !take_halt);
  assign npc_state  = state;
  assign pc_new_address = take_redir ? target : pc_stop ? instruction_address : instruction_address + 16'd2;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (take_halt) state_nx = HALT;
    else if (take_redir) begin
      state_nx = FLUSH_CYCLES > 1 ? FLUSH : RUN;
      cnt_nx   = FLUSH_CYCLES > 1 ? 4'(FLUSH_CYCLES - 2) : cnt;
    end else if (take_stall) begin
      state_nx = STALL_CYCLES > 1 ? STALL : RUN;
      cnt_nx   = STALL_CYCLES > 1 ? 4'(STALL_CYCLES - 2) : cnt;
    end else if (state == STALL || state == FLUSH) begin
      state_nx = cnt == 4'd0 ? RUN : state;
      cnt_nx   = cnt == 4'd0 ? cnt : cnt - 4'd1;
    end
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
`ifdef NPC_REDIRECT_COUNT_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) redirect_count <= 16'd0;
    else if (take_redir && redirect_count != 16'hFFFF) redirect_count <= redirect_count + 16'd1;
`endif
endmodule
